// File: rtl/output_link_ctrl_if.sv
// Flit type definitions shared by the link stage, plus the flit/valid bus interface
// used for both the crossbar-side input and the link-side output.
package noc_params;
    localparam int VC_NUM = 2;
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t     label;
        logic [VC_W-1:0] vc_id;
        logic [15:0]     payload;
    } flit_t;
endpackage

interface output_link_ctrl_if;
    import noc_params::*;

    flit_t data;
    logic  valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/output_link_ctrl.sv
// Output link stage: per-VC staging FIFOs, on/off flow control, round-robin VC pick,
// one registered flit per cycle. Optional OUTPUT_LINK_STATS_EN adds sent_cnt_o.
module output_link_ctrl
    import noc_params::*;
#(
    parameter int STAGE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output_link_ctrl_if.slave    in_i,
    input  logic [VC_NUM-1:0]    on_off_i,
    output logic [VC_NUM-1:0]    full_o,
    output_link_ctrl_if.master   link_o,
`ifdef OUTPUT_LINK_STATS_EN
    output logic [15:0]          sent_cnt_o,
`endif
    output logic                 overflow_o
);
    localparam int PTR_W = $clog2(STAGE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [VC_NUM-1:0] on_off_q;
    logic [VC_NUM-1:0] wr_sel;
    logic [VC_NUM-1:0] push;
    logic [VC_NUM-1:0] pop;
    logic [VC_NUM-1:0] elig;
    flit_t             head_flit [VC_NUM];

    logic [VC_W-1:0]   rr_ptr_q;
    logic [VC_W-1:0]   grant_vc;
    logic              grant_valid;

    flit_t             data_q;
    logic              valid_q;
    logic              overflow_q;

    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            flit_t            mem [STAGE_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q;
            logic [PTR_W-1:0] rd_ptr_q;
            logic [CNT_W-1:0] cnt_q;

            // Full and eligibility come from the registered count only, so a pop in
            // the same cycle never rescues a write to a full VC.
            assign wr_sel[gi]    = in_i.valid && (in_i.data.vc_id == VC_W'(gi));
            assign full_o[gi]    = (cnt_q == CNT_W'(STAGE_DEPTH));
            assign elig[gi]      = (cnt_q != '0) && on_off_q[gi];
            assign push[gi]      = wr_sel[gi] && !full_o[gi];
            assign pop[gi]       = grant_valid && (grant_vc == VC_W'(gi));
            assign head_flit[gi] = mem[rd_ptr_q];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop[gi])  rd_ptr_q <= rd_ptr_q + 1'b1;
                    case ({push[gi], pop[gi]})
                        2'b10:   cnt_q <= cnt_q + 1'b1;
                        2'b01:   cnt_q <= cnt_q - 1'b1;
                        default: cnt_q <= cnt_q;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) mem[wr_ptr_q] <= in_i.data;
            end
        end
    endgenerate

    // Scan from farthest to nearest so the VC closest after rr_ptr_q wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_vc    = '0;
        for (int i = VC_NUM; i >= 1; i--) begin
            idx = (int'(rr_ptr_q) + i) % VC_NUM;
            if (elig[idx]) begin
                grant_valid = 1'b1;
                grant_vc    = VC_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_off_q   <= '0;
            rr_ptr_q   <= VC_W'(VC_NUM - 1);
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            on_off_q   <= on_off_i;
            overflow_q <= |(wr_sel & full_o);
            valid_q    <= grant_valid;
            if (grant_valid) begin
                data_q   <= head_flit[grant_vc];
                rr_ptr_q <= grant_vc;
            end
        end
    end

`ifdef OUTPUT_LINK_STATS_EN
    logic [15:0] sent_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sent_cnt_q <= '0;
        else if (grant_valid) sent_cnt_q <= sent_cnt_q + 16'd1;
    end

    assign sent_cnt_o = sent_cnt_q;
`endif

    assign link_o.data  = data_q;
    assign link_o.valid = valid_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_output_link_ctrl.sv
// Directed bench for output_link_ctrl: stimulus pushes expected link flits (with their
// expected edge) into a scoreboard; a negedge monitor pops and compares every link flit.
module tb_output_link_ctrl;
    import noc_params::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [VC_NUM-1:0] on_off = '0;
    logic [VC_NUM-1:0] full;
    logic              overflow;
`ifdef OUTPUT_LINK_STATS_EN
    logic [15:0]       sent_cnt;
`endif

    output_link_ctrl_if in_bus ();
    output_link_ctrl_if link_bus ();

    output_link_ctrl #(.STAGE_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_i       (in_bus),
        .on_off_i   (on_off),
        .full_o     (full),
        .link_o     (link_bus),
`ifdef OUTPUT_LINK_STATS_EN
        .sent_cnt_o (sent_cnt),
`endif
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        flit_t f;
        int    at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (!rst && link_bus.valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL link_unexpected: got flit %h at edge %0d, required no flit",
                         link_bus.data, cyc);
            end else begin
                e = sb.pop_front();
                if (link_bus.data !== e.f || cyc != e.at) begin
                    n_err++;
                    $display("FAIL link_flit: got %h at edge %0d, required %h at edge %0d",
                             link_bus.data, cyc, e.f, e.at);
                end else begin
                    $display("link flit %h at edge %0d ok", link_bus.data, cyc);
                end
            end
        end
    end

    function automatic flit_t mk(flit_label_t l, int vc, logic [15:0] p);
        flit_t f;
        f.label   = l;
        f.vc_id   = VC_W'(vc);
        f.payload = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_bus.valid = 1'b0;
        on_off       = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input flit_t f);
        in_bus.data  = f;
        in_bus.valid = 1'b1;
        tick();
        in_bus.valid = 1'b0;
    endtask

    task automatic expect_at(input flit_t f, input int at);
        exp_t x;
        x.f  = f;
        x.at = at;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t       a, b, c, d, f;
        flit_label_t labels [4];
        int          m;
        labels[0] = HEAD; labels[1] = BODY; labels[2] = BODY; labels[3] = TAIL;
        in_bus.valid = 1'b0;
        in_bus.data  = '0;

        // 1: reset state and single-flit latency
        do_reset();
        check("rst_valid", 32'(link_bus.valid), 32'd0);
        check("rst_data", 32'(link_bus.data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        on_off = 2'b11;
        tick();
        tick();
        a = mk(HEAD, 0, 16'h1001);
        expect_at(a, cyc + 2);
        wr(a);
        tick();
        tick();

        // 2: round-robin interleave vc0,vc1,vc0,vc1
        do_reset();
        a = mk(HEAD, 0, 16'h2001);
        b = mk(TAIL, 0, 16'h2002);
        c = mk(HEAD, 1, 16'h2101);
        d = mk(TAIL, 1, 16'h2102);
        wr(a); wr(b); wr(c); wr(d);
        check("t2_full_both", 32'(full), 32'h3);
        m = cyc;
        on_off = 2'b11;
        expect_at(a, m + 2);
        expect_at(c, m + 3);
        expect_at(b, m + 4);
        expect_at(d, m + 5);
        repeat (6) tick();

        // 3: vc0 OFF blocks only vc0; turning it ON releases after 2 and 3 cycles
        do_reset();
        on_off = 2'b10;
        a = mk(HEAD, 0, 16'h3001);
        b = mk(TAIL, 0, 16'h3002);
        c = mk(HEADTAIL, 1, 16'h3101);
        wr(a);
        wr(b);
        expect_at(c, cyc + 2);
        wr(c);
        repeat (3) tick();
        check("t3_full_vc0", 32'(full), 32'h1);
        m = cyc;
        on_off = 2'b11;
        expect_at(a, m + 2);
        expect_at(b, m + 3);
        repeat (5) tick();

        // 4: overflow on full, OFF vc1; stored flits survive
        do_reset();
        on_off = 2'b01;
        a = mk(HEAD, 1, 16'h4101);
        b = mk(BODY, 1, 16'h4102);
        c = mk(TAIL, 1, 16'h4103);
        wr(a);
        wr(b);
        check("t4_full_vc1", 32'(full), 32'h2);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        wr(c);
        check("t4_overflow_pulse", 32'(overflow), 32'd1);
        tick();
        check("t4_overflow_clear", 32'(overflow), 32'd0);
        check("t4_full_kept", 32'(full), 32'h2);
        m = cyc;
        on_off = 2'b11;
        expect_at(a, m + 2);
        expect_at(b, m + 3);
        repeat (5) tick();

        // 5: back-to-back packet on vc1, never full
        do_reset();
        on_off = 2'b11;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            f = mk(labels[i], 1, 16'h5100 + 16'(i));
            expect_at(f, cyc + 2);
            wr(f);
            check("t5_full_vc1_low", 32'(full[1]), 32'd0);
        end
        repeat (3) tick();
`ifdef OUTPUT_LINK_STATS_EN
        check("t5_sent_cnt", 32'(sent_cnt), 32'd4);
`endif

        // 6: asynchronous reset mid-packet
        do_reset();
        on_off = 2'b11;
        tick();
        tick();
        a = mk(HEAD, 0, 16'h6001);
        b = mk(BODY, 0, 16'h6002);
        expect_at(a, cyc + 2);
        wr(a);
        wr(b);
        check("t6_valid_before_rst", 32'(link_bus.valid), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(link_bus.valid), 32'd0);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_data", 32'(link_bus.data), 32'd0);
`ifdef OUTPUT_LINK_STATS_EN
        check("t6_rst_sent_cnt", 32'(sent_cnt), 32'd0);
`endif
        tick();
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
